// File: rtl/idu_pair.sv
// Issue-pairing stage: turns a two-slot fetch packet into registered slot-0/slot-1
// issue packets, splitting conflicting pairs over two cycles and counting the splits.
module idu_pair #(
  parameter bit DUAL_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i0_valid,
  input  logic [31:0]      in_i0_inst,
  input  logic             in_i1_valid,
  input  logic [31:0]      in_i1_inst,
  input  logic [31:0]      in_addr,
  output logic             stall_ifu,
  input  logic             stall_dec,
  input  logic             flush,
  output logic             is0_valid,
  output logic [31:0]      is0_inst,
  output logic [31:0]      is0_pc,
  output logic             is1_valid,
  output logic [31:0]      is1_inst,
  output logic [31:0]      is1_pc,
  output logic [CNT_W-1:0] split_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {PASS, SPLIT} state_t;

  function automatic logic rs1_used(input logic [31:0] inst);
    return !(inst[6:0] == OP_LUI || inst[6:0] == OP_AUIPC || inst[6:0] == OP_JAL);
  endfunction

  function automatic logic rs2_used(input logic [31:0] inst);
    return inst[6:0] == OP_OP || inst[6:0] == OP_STORE || inst[6:0] == OP_BRANCH;
  endfunction

  function automatic logic rd_written(input logic [31:0] inst);
    return !(inst[6:0] == OP_STORE || inst[6:0] == OP_BRANCH) && inst[11:7] != 5'd0;
  endfunction

  function automatic logic is_mem(input logic [31:0] inst);
    return inst[6:0] == OP_LOAD || inst[6:0] == OP_STORE;
  endfunction

  state_t           state_q, state_d;
  logic             raw_hz, conflict, cnt_inc;
  logic             nxt0_vld, nxt1_vld;
  logic [31:0]      nxt0_inst, nxt0_pc, nxt1_inst, nxt1_pc;
  logic             is0_vld_p1, is1_vld_p1;
  logic [31:0]      is0_inst_p1, is0_pc_p1, is1_inst_p1, is1_pc_p1;
  logic [CNT_W-1:0] split_cnt_p1;

  always_comb begin
    raw_hz = rd_written(in_i0_inst) &&
             ((rs1_used(in_i1_inst) && in_i1_inst[19:15] == in_i0_inst[11:7]) ||
              (rs2_used(in_i1_inst) && in_i1_inst[24:20] == in_i0_inst[11:7]));
    conflict = raw_hz
            || (is_mem(in_i0_inst) && is_mem(in_i1_inst))
            || in_i0_inst[6:0] == OP_JAL || in_i0_inst[6:0] == OP_JALR
            || in_i0_inst[6:0] == OP_BRANCH
            || in_i0_inst[6:0] == OP_SYSTEM || in_i1_inst[6:0] == OP_SYSTEM
            || !DUAL_EN;
  end

  // Stage p0 -> p1: pairing decision and next issue packet
  always_comb begin
    state_d   = state_q;
    stall_ifu = stall_dec;
    cnt_inc   = 1'b0;
    nxt0_vld  = 1'b0;
    nxt0_inst = in_i0_inst;
    nxt0_pc   = in_addr;
    nxt1_vld  = 1'b0;
    nxt1_inst = in_i1_inst;
    nxt1_pc   = in_addr | 32'd4;
    case (state_q)
      PASS: begin
        if (in_i0_valid && in_i1_valid) begin
          nxt0_vld = 1'b1;
          if (conflict) begin
            stall_ifu = 1'b1;
            state_d   = SPLIT;
            cnt_inc   = 1'b1;
          end else begin
            nxt1_vld = 1'b1;
          end
        end else if (in_i0_valid) begin
          nxt0_vld = 1'b1;
        end else if (in_i1_valid) begin
          nxt0_vld  = 1'b1;
          nxt0_inst = in_i1_inst;
          nxt0_pc   = in_addr | 32'd4;
        end
      end
      SPLIT: begin
        nxt0_vld  = in_i1_valid;
        nxt0_inst = in_i1_inst;
        nxt0_pc   = in_addr | 32'd4;
        state_d   = PASS;
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PASS;
      is0_vld_p1   <= 1'b0;
      is1_vld_p1   <= 1'b0;
      split_cnt_p1 <= '0;
    end else if (flush) begin
      state_q    <= PASS;
      is0_vld_p1 <= 1'b0;
      is1_vld_p1 <= 1'b0;
    end else if (!stall_dec) begin
      state_q      <= state_d;
      is0_vld_p1   <= nxt0_vld;
      is1_vld_p1   <= nxt1_vld;
      split_cnt_p1 <= split_cnt_p1 + {{(CNT_W-1){1'b0}}, cnt_inc};
    end
  end

  always_ff @(posedge clk) begin
    if (!stall_dec) begin
      is0_inst_p1 <= nxt0_inst;
      is0_pc_p1   <= nxt0_pc;
      is1_inst_p1 <= nxt1_inst;
      is1_pc_p1   <= nxt1_pc;
    end
  end

  assign is0_valid = is0_vld_p1;
  assign is0_inst  = is0_inst_p1;
  assign is0_pc    = is0_pc_p1;
  assign is1_valid = is1_vld_p1;
  assign is1_inst  = is1_inst_p1;
  assign is1_pc    = is1_pc_p1;
  assign split_cnt = split_cnt_p1;

endmodule

// File: tb/tb_idu_pair.sv
// Directed testbench for idu_pair: pairing, splitting, stall, flush and async reset.
module tb_idu_pair;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_i0_valid, in_i1_valid;
  logic [31:0] in_i0_inst, in_i1_inst, in_addr;
  logic        stall_ifu, stall_dec, flush;
  logic        is0_valid, is1_valid;
  logic [31:0] is0_inst, is0_pc, is1_inst, is1_pc;
  logic [31:0] split_cnt;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] exp_cnt = 32'd0;

  idu_pair #(.DUAL_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_i0_valid(in_i0_valid), .in_i0_inst(in_i0_inst),
    .in_i1_valid(in_i1_valid), .in_i1_inst(in_i1_inst),
    .in_addr(in_addr), .stall_ifu(stall_ifu), .stall_dec(stall_dec), .flush(flush),
    .is0_valid(is0_valid), .is0_inst(is0_inst), .is0_pc(is0_pc),
    .is1_valid(is1_valid), .is1_inst(is1_inst), .is1_pc(is1_pc),
    .split_cnt(split_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [31:0] i0, input logic v1,
                       input logic [31:0] i1, input logic [31:0] addr);
    in_i0_valid = v0; in_i0_inst = i0;
    in_i1_valid = v1; in_i1_inst = i1;
    in_addr     = addr;
    #1;
  endtask

  // Drives one packet and checks the full issue sequence it should produce.
  task automatic packet(input string tag, input logic v0, input logic [31:0] i0,
                        input logic v1, input logic [31:0] i1,
                        input logic [31:0] addr, input logic exp_split);
    drive(v0, i0, v1, i1, addr);
    chk({tag, ".stall_ifu"}, {31'd0, stall_ifu}, {31'd0, exp_split});
    if (exp_split) exp_cnt++;
    tick();
    chk({tag, ".is0_valid"}, {31'd0, is0_valid}, {31'd0, v0 | v1});
    if (v0 | v1) begin
      chk({tag, ".is0_inst"}, is0_inst, v0 ? i0 : i1);
      chk({tag, ".is0_pc"}, is0_pc, v0 ? addr : (addr | 32'd4));
    end
    chk({tag, ".is1_valid"}, {31'd0, is1_valid}, {31'd0, v0 & v1 & ~exp_split});
    if (v0 & v1 & ~exp_split) begin
      chk({tag, ".is1_inst"}, is1_inst, i1);
      chk({tag, ".is1_pc"}, is1_pc, addr | 32'd4);
    end
    chk({tag, ".split_cnt"}, split_cnt, exp_cnt);
    if (exp_split) begin
      chk({tag, ".split_stall_ifu"}, {31'd0, stall_ifu}, 32'd0);
      tick();
      chk({tag, ".split_is0_valid"}, {31'd0, is0_valid}, 32'd1);
      chk({tag, ".split_is0_inst"}, is0_inst, i1);
      chk({tag, ".split_is0_pc"}, is0_pc, addr | 32'd4);
      chk({tag, ".split_is1_valid"}, {31'd0, is1_valid}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; stall_dec = 1'b0; flush = 1'b0;
    in_i0_valid = 1'b0; in_i1_valid = 1'b0;
    in_i0_inst = 32'd0; in_i1_inst = 32'd0; in_addr = 32'd0;
    #12;
    chk("rst.is0_valid", {31'd0, is0_valid}, 32'd0);
    chk("rst.is1_valid", {31'd0, is1_valid}, 32'd0);
    chk("rst.split_cnt", split_cnt, 32'd0);
    rst = 1'b0;

    packet("dual",    1, 32'h00500093, 1, 32'h00700193, 32'h100, 0);
    packet("raw_rs1", 1, 32'h00500093, 1, 32'h00108113, 32'h108, 1);
    packet("odd",     0, 32'h0,        1, 32'h0080006f, 32'h200, 0);
    packet("i0only",  1, 32'h00700193, 0, 32'h0,        32'h208, 0);
    packet("mem",     1, 32'h00032283, 1, 32'h0053a223, 32'h210, 1);
    packet("mem2",    1, 32'h00032283, 1, 32'h0083a223, 32'h218, 1);
    packet("x0",      1, 32'h00000013, 1, 32'h00000093, 32'h220, 0);
    packet("jal",     1, 32'h0080006f, 1, 32'h00700193, 32'h228, 1);
    packet("sys",     1, 32'h00500093, 1, 32'h00000073, 32'h230, 1);
    packet("raw_rs2", 1, 32'h00500093, 1, 32'h001101b3, 32'h238, 1);
    packet("lui",     1, 32'h00500093, 1, 32'h000081b7, 32'h240, 0);
    packet("st_alu",  1, 32'h0083a223, 1, 32'h00120293, 32'h248, 0);
    packet("none",    0, 32'h0,        0, 32'h0,        32'h250, 0);

    // Flush during the split cycle: the held i1 must never issue
    drive(1, 32'h00500093, 1, 32'h00108113, 32'h260);
    exp_cnt++;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush.is0_valid", {31'd0, is0_valid}, 32'd0);
    chk("flush.is1_valid", {31'd0, is1_valid}, 32'd0);
    chk("flush.split_cnt", split_cnt, exp_cnt);
    packet("post_flush", 1, 32'h00700193, 0, 32'h0, 32'h300, 0);

    // Downstream stall for three cycles with a conflicting packet waiting
    packet("pre_stall", 1, 32'h00500093, 1, 32'h00700193, 32'h310, 0);
    stall_dec = 1'b1;
    drive(1, 32'h00032283, 1, 32'h0053a223, 32'h320);
    for (int c = 0; c < 3; c++) begin
      chk("stall.stall_ifu", {31'd0, stall_ifu}, 32'd1);
      tick();
      chk("stall.is0_inst", is0_inst, 32'h00500093);
      chk("stall.is0_pc", is0_pc, 32'h310);
      chk("stall.is1_valid", {31'd0, is1_valid}, 32'd1);
      chk("stall.is1_pc", is1_pc, 32'h314);
      chk("stall.split_cnt", split_cnt, exp_cnt);
    end
    stall_dec = 1'b0;
    packet("post_stall", 1, 32'h00032283, 1, 32'h0053a223, 32'h320, 1);

    // Flush wins over a simultaneous stall
    packet("pre_fs", 1, 32'h00500093, 1, 32'h00700193, 32'h330, 0);
    stall_dec = 1'b1; flush = 1'b1;
    tick();
    stall_dec = 1'b0; flush = 1'b0;
    chk("flush_stall.is0_valid", {31'd0, is0_valid}, 32'd0);
    chk("flush_stall.is1_valid", {31'd0, is1_valid}, 32'd0);

    // Asynchronous reset in the middle of a split
    drive(1, 32'h0080006f, 1, 32'h00700193, 32'h340);
    tick();
    chk("arst_pre.split_cnt", split_cnt, exp_cnt + 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.is0_valid", {31'd0, is0_valid}, 32'd0);
    chk("arst.split_cnt", split_cnt, 32'd0);
    #1 rst = 1'b0;
    exp_cnt = 32'd0;
    packet("post_rst", 1, 32'h00700193, 0, 32'h0, 32'h400, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
